// File: rtl/rv32_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch and load/store.
// It keeps one transaction outstanding at a time, with an optional ack timeout.
module rv32_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            owner_ls_q;  // owner of the transaction in flight
  logic            last_ls_q;   // last grant went to load/store

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b1;
      if_gnt_o    <= 1'b0;
      ls_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      ls_rdata_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_gnt_o    <= 1'b0;
      ls_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      err_o       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req_i || ls_req_i) begin
            if (if_req_i && (!ls_req_i || last_ls_q)) begin
              owner_ls_q  <= 1'b0;
              last_ls_q   <= 1'b0;
              if_gnt_o    <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_be_o    <= '1;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
            end else begin
              owner_ls_q  <= 1'b1;
              last_ls_q   <= 1'b1;
              ls_gnt_o    <= 1'b1;
              mem_we_o    <= ls_we_i;
              mem_be_o    <= ls_be_i;
              mem_addr_o  <= ls_addr_i;
              mem_wdata_o <= ls_wdata_i;
            end
            mem_req_o <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          // Response is registered on the way into StResp so rvalid lines up with it.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state_q   <= StResp;
            if (owner_ls_q) begin
              ls_rvalid_o <= 1'b1;
              ls_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            end else begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= mem_rdata_i;
            end
          end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            state_q   <= StResp;
            if (owner_ls_q) begin
              ls_rvalid_o <= 1'b1;
              ls_rdata_o  <= '0;
            end else begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= '0;
            end
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
